sensor_poll_arbiter: RTL

//  Parametrised successor of the single-sensor UART request arbiter: addresses one of N sensors.
//  For each request it sends one request byte, then collects a multi-byte response frame.

---
 rtl/sensor_poll_pkg.sv | 39 +++
 rtl/sensor_poll_arbiter_resp_timer.sv | 35 +++
 rtl/sensor_poll_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sensor_poll_pkg.sv
// Shared definitions for the sensor poll arbiter.
//  - FSM state encodings (plain localparams so older tools and waveform scripts keep decoding them)
//  - completion status codes reported on the status port
//  - the request opcode placed in the upper bits of the request byte
//  - the XOR checksum used to validate response frames
package sensor_poll_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSend    = 3'd1;
  localparam logic [2:0] StWaitTx  = 3'd2;
  localparam logic [2:0] StWaitRsp = 3'd3;
  localparam logic [2:0] StCheck   = 3'd4;
  localparam logic [2:0] StFinish  = 3'd5;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_CHKSUM  = 2'b10;
  localparam logic [1:0] ST_ADDR    = 2'b11;

  localparam logic [7:0] REQ_OPCODE = 8'h00;

  // Largest payload the checksum helper folds; DATA_BYTES must not exceed it.
  localparam int unsigned MaxDataBytes = 4;

  // seed ^ byte0 ^ byte1 ^ ... over the lowest n_bytes bytes of payload.
  function automatic logic [7:0] xor_checksum(input logic [7:0]  seed,
                                              input logic [31:0] payload,
                                              input int unsigned n_bytes);
    logic [7:0] acc;
    acc = seed;
    for (int unsigned i = 0; i < MaxDataBytes; i++) begin
      if (i < n_bytes) begin
        acc = acc ^ payload[i*8 +: 8];
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/sensor_poll_arbiter_resp_timer.sv
// resp_timer: response-frame watchdog for the sensor poll arbiter.
// Counts clock cycles while enabled and flags expiry on the last allowed cycle.
// Ports:
//  clock   in  system clock
//  reset   in  synchronous, active-high
//  enable  in  count this cycle (arbiter is waiting for a response)
//  clear   in  restart the count from zero (takes priority over enable)
//  expired out high while enabled and the count has reached TIMEOUT_CYC-1
module resp_timer #(
  parameter int unsigned TIMEOUT_CYC = 500000000,
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [CntW-1:0] count_q;
  logic            at_limit;

  assign at_limit = (count_q == CntW'(TIMEOUT_CYC - 1));
  assign expired  = enable && at_limit;

  // Saturates at the limit so a stalled arbiter cannot wrap back to zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && !at_limit) begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/sensor_poll_arbiter.sv
// sensor_poll_arbiter: polls one of N_SENSORS sensors over an external byte UART.
// Sends one request byte, collects DATA_BYTES payload bytes plus a trailing XOR checksum,
// and reports the payload and a completion status to the custom-instruction side.
// Optional build macro RETRY_EN: failed attempts (timeout or bad checksum) are resent up to
// MAX_RETRY extra times before the failure is reported. Without it every failure finishes
// immediately.
// Ports:
//  clock    in   system clock
//  reset    in   synchronous, active-high; aborts any request without a done pulse
//  start    in   request strobe, honoured only when idle
//  req_addr in   sensor index, latched on an accepted start
//  tx_byte  out  request byte for uart_tx, stable from the send cycle until tx_done
//  tx_dv    out  one-cycle send strobe to uart_tx
//  tx_done  in   one-cycle completion pulse from uart_tx
//  rx_dv    in   received-byte strobe from uart_rx (ignored unless awaiting a response)
//  rx_byte  in   received byte
//  busy     out  high whenever a request is in progress
//  done     out  one-cycle completion pulse; result/status valid from this cycle
//  result   out  last good payload, first received byte in the MSBs
//  status   out  00 ok, 01 timeout, 10 checksum error, 11 address error
module sensor_poll_arbiter
  import sensor_poll_pkg::*;
#(
  parameter int unsigned N_SENSORS   = 32,
  parameter int unsigned DATA_BYTES  = 2,
  parameter logic [7:0]  CHK_SEED    = 8'h37,
  parameter int unsigned TIMEOUT_CYC = 500000000,
  parameter int unsigned MAX_RETRY   = 3,
  // One bit wider than the sensor index so out-of-range indices from the CPU are
  // representable and can be rejected rather than silently aliased.
  localparam int unsigned ADDR_W     = $clog2(N_SENSORS) + 1,
  localparam int unsigned RES_W      = 8 * DATA_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        tx_byte,
  output logic              tx_dv,
  input  logic              tx_done,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic [1:0]        status
);

  localparam int unsigned FrameW = 8 * (DATA_BYTES + 1);
  localparam int unsigned IdxW   = $clog2(DATA_BYTES + 2);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [1:0]        status_q, status_d;

  logic              fail;
  logic [1:0]        fail_code;
  logic              tmr_expired;
  logic [RES_W-1:0]  payload;
  logic [7:0]        computed_chk;

`ifdef RETRY_EN
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RetryW-1:0] retry_q, retry_d;
`endif

  // Frame buffer shifts bytes in at the bottom: payload ends up above the checksum byte.
  assign payload      = frame_q[FrameW-1:8];
  assign computed_chk = xor_checksum(CHK_SEED, 32'(payload), DATA_BYTES);

  resp_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_resp_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (state_q == StWaitRsp),
    .clear   ((state_q == StWaitTx) && tx_done),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    result_d  = result_q;
    status_d  = status_q;
    fail      = 1'b0;
    fail_code = ST_OK;
`ifdef RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          if (32'(req_addr) < N_SENSORS) begin
            addr_d  = req_addr;
            state_d = StSend;
`ifdef RETRY_EN
            retry_d = '0;
`endif
          end else begin
            status_d = ST_ADDR;
            state_d  = StFinish;
          end
        end
      end

      StSend: state_d = StWaitTx;

      StWaitTx: begin
        if (tx_done) begin
          idx_d   = '0;
          state_d = StWaitRsp;
        end
      end

      StWaitRsp: begin
        if (rx_dv) begin
          frame_d = {frame_q[FrameW-9:0], rx_byte};
          idx_d   = idx_q + IdxW'(1);
        end
        // A byte that completes the frame wins over a simultaneous timeout.
        if (rx_dv && (idx_q == IdxW'(DATA_BYTES))) begin
          state_d = StCheck;
        end else if (tmr_expired) begin
          fail      = 1'b1;
          fail_code = ST_TIMEOUT;
        end
      end

      StCheck: begin
        if (computed_chk == frame_q[7:0]) begin
          result_d = payload;
          status_d = ST_OK;
          state_d  = StFinish;
        end else begin
          fail      = 1'b1;
          fail_code = ST_CHKSUM;
        end
      end

      StFinish: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    if (fail) begin
`ifdef RETRY_EN
      if (retry_q < RetryW'(MAX_RETRY)) begin
        retry_d = retry_q + RetryW'(1);
        state_d = StSend;
      end else begin
        status_d = fail_code;
        state_d  = StFinish;
      end
`else
      status_d = fail_code;
      state_d  = StFinish;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      result_q <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

`ifdef RETRY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // Strobes are masked by reset so an abort in the same cycle never reaches the UART or CPU.
  assign tx_dv   = (state_q == StSend) && !reset;
  assign done    = (state_q == StFinish) && !reset;
  assign busy    = (state_q != StIdle);
  assign tx_byte = REQ_OPCODE | 8'(addr_q);
  assign result  = result_q;
  assign status  = status_q;

endmodule
